// File: rtl/tdm_burst_reader.sv
// Drains fixed-length bursts from the upstream FIFO into one assigned slot of a TDM frame.
// Generates frame/slot timing and counts own-slots skipped for lack of buffered data.
module tdm_burst_reader #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SLOT_LEN   = 16,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [$clog2(NUM_SLOTS)-1:0] slot_sel,
    input  logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         fifo_ren,
    input  logic [WIDTH-1:0]             fifo_dout,
    output logic [WIDTH-1:0]             tdm_data,
    output logic                         tdm_valid,
    output logic                         tdm_sof,
    output logic [$clog2(NUM_SLOTS)-1:0] tdm_slot,
    output logic [15:0]                  skip_cnt
);
    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
    localparam int unsigned CYC_W  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int unsigned RD_W   = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_READ = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W-1:0] my_slot;
    logic [SLOT_W-1:0] eff_slot;
    logic [RD_W-1:0]   rd_cnt;
    logic              rd_valid_d1;
    logic              frame_start;
    logic              own_start;
    logic              level_ok;
    logic              burst_go;
    logic              skip;
    logic              rd_last;
    logic              cyc_wrap;

    // Slot selection is taken live on the frame-start cycle, then held for the frame
    assign frame_start = (cyc_cnt == '0) && (slot_cnt == '0);
    assign eff_slot    = frame_start ? slot_sel : my_slot;
    assign own_start   = (state == S_WAIT) && en && (cyc_cnt == '0) && (slot_cnt == eff_slot);
    assign level_ok    = 32'(fifo_level) >= BURST_LEN;
    assign burst_go    = own_start && level_ok;
    assign skip        = own_start && !level_ok;
    assign rd_last     = rd_cnt == RD_W'(BURST_LEN - 1);
    assign cyc_wrap    = cyc_cnt == CYC_W'(SLOT_LEN - 1);
    assign tdm_slot    = slot_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A burst only ends after its last read; dropping en mid-burst is honoured afterwards
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (burst_go) begin
                    state_nxt = (BURST_LEN > 1) ? S_READ : S_WAIT;
                end
            end
            S_READ: begin
                if (rd_last) state_nxt = S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_ren = 1'b0;
        tdm_sof  = 1'b0;
        fifo_ren = (state == S_READ) || burst_go;
        tdm_sof  = (state != S_IDLE) && frame_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt  <= '0;
            slot_cnt <= '0;
        end else if ((state == S_IDLE) || (state_nxt == S_IDLE)) begin
            cyc_cnt  <= '0;
            slot_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_wrap ? '0 : cyc_cnt + CYC_W'(1);
            if (cyc_wrap) begin
                slot_cnt <= (slot_cnt == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_cnt + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            my_slot  <= '0;
            rd_cnt   <= '0;
            skip_cnt <= '0;
        end else begin
            if (frame_start) my_slot <= slot_sel;
            if (burst_go) begin
                rd_cnt <= RD_W'(1);
            end else if (state == S_READ) begin
                rd_cnt <= rd_last ? '0 : rd_cnt + RD_W'(1);
            end
            if (skip && (skip_cnt != 16'hFFFF)) skip_cnt <= skip_cnt + 16'd1;
        end
    end

    // Two-stage output path: FIFO read latency, then the TDM output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_d1 <= 1'b0;
            tdm_valid   <= 1'b0;
            tdm_data    <= '0;
        end else begin
            rd_valid_d1 <= fifo_ren;
            tdm_valid   <= rd_valid_d1;
            tdm_data    <= rd_valid_d1 ? fifo_dout : '0;
        end
    end

endmodule

// File: tb/tb_tdm_burst_reader.sv
// Directed bench for tdm_burst_reader: FIFO model, expected-word scoreboard with
// an independent output monitor, and per-cycle timing windows for each scenario.
module tb_tdm_burst_reader;
    localparam int NONE = -100;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] slot_sel;
    logic [4:0] fifo_level;
    logic       fifo_ren;
    logic [7:0] fifo_dout;
    logic [7:0] tdm_data;
    logic       tdm_valid;
    logic       tdm_sof;
    logic [1:0] tdm_slot;
    logic [15:0] skip_cnt;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    tdm_burst_reader #(
        .WIDTH(8), .FIFO_DEPTH(16), .NUM_SLOTS(4), .SLOT_LEN(16), .BURST_LEN(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .slot_sel   (slot_sel),
        .fifo_level (fifo_level),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .tdm_data   (tdm_data),
        .tdm_valid  (tdm_valid),
        .tdm_sof    (tdm_sof),
        .tdm_slot   (tdm_slot),
        .skip_cnt   (skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read FIFO model; an empty read returns a marker word
    always @(posedge clk) begin
        if (fifo_ren) begin
            if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
            else                   fifo_dout <= 8'hEE;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every valid word must be the next expected word
    initial begin
        logic [7:0] w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tdm_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tdm_data_unexpected: got %0h expected no word at %0t", tdm_data, $time);
                    end else begin
                        w = exp_q.pop_front();
                        chk("tdm_data", 32'(tdm_data), 32'(w));
                    end
                end else begin
                    chk("tdm_data_idle", 32'(tdm_data), 32'h0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_words(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ren"},   32'(fifo_ren),  32'h0);
        chk({tag, "_valid"}, 32'(tdm_valid), 32'h0);
        chk({tag, "_data"},  32'(tdm_data),  32'h0);
        chk({tag, "_sof"},   32'(tdm_sof),   32'h0);
        chk({tag, "_slot"},  32'(tdm_slot),  32'h0);
        chk({tag, "_skip"},  32'(skip_cnt),  32'h0);
    endtask

    // Called at a negedge in WAIT; returns at the negedge of cycle 0 of a fresh frame
    task automatic restart();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    // Checks cycles c0..c1-1 of the current run; reads on the two windows, outputs 2 later
    task automatic run_span(input int c0, input int c1, input int lo1, input int hi1,
                            input int lo2, input int hi2);
        for (int c = c0; c < c1; c++) begin
            bit r;
            bit v;
            r = (c >= lo1 && c <= hi1) || (c >= lo2 && c <= hi2);
            v = (c - 2 >= lo1 && c - 2 <= hi1) || (c - 2 >= lo2 && c - 2 <= hi2);
            chk($sformatf("fifo_ren@%0d", c),  32'(fifo_ren),  32'(r));
            chk($sformatf("tdm_valid@%0d", c), 32'(tdm_valid), 32'(v));
            chk($sformatf("tdm_sof@%0d", c),   32'(tdm_sof),   32'(c % 64 == 0));
            chk($sformatf("tdm_slot@%0d", c),  32'(tdm_slot),  32'((c / 16) % 4));
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        slot_sel = 2'd0;
        fifo_level = 5'd0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Slot 2 with a full FIFO: frame timing and burst position
        slot_sel = 2'd2;
        fifo_level = 5'd16;
        push_words(8'hA0, 8);
        en = 1'b1;
        @(negedge clk);
        run_span(0, 66, 32, 39, NONE, NONE);

        // Slot 0: data order and two-cycle latency
        slot_sel = 2'd0;
        push_words(8'h10, 8);
        restart();
        run_span(0, 12, 0, 7, NONE, NONE);

        // One word short skips the slot; exactly a burst's worth qualifies next frame
        slot_sel = 2'd1;
        fifo_level = 5'd7;
        push_words(8'h30, 8);
        restart();
        run_span(0, 16, NONE, NONE, NONE, NONE);
        chk("skip_before", 32'(skip_cnt), 32'd0);
        run_span(16, 17, NONE, NONE, NONE, NONE);
        chk("skip_after", 32'(skip_cnt), 32'd1);
        fifo_level = 5'd8;
        run_span(17, 90, 80, 87, NONE, NONE);

        // Slot change mid-frame takes effect only at the next frame
        slot_sel = 2'd1;
        fifo_level = 5'd16;
        push_words(8'h40, 16);
        restart();
        run_span(0, 20, 16, 23, NONE, NONE);
        slot_sel = 2'd3;
        run_span(20, 122, 16, 23, 112, 119);
        chk("skip_hold", 32'(skip_cnt), 32'd1);

        // Dropping en during the burst lets it finish, then the block idles
        slot_sel = 2'd0;
        push_words(8'h50, 8);
        restart();
        run_span(0, 2, 0, 7, NONE, NONE);
        en = 1'b0;
        run_span(2, 12, 0, 7, NONE, NONE);
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("idle_slot@%0d", i), 32'(tdm_slot), 32'h0);
            chk($sformatf("idle_ren@%0d", i),  32'(fifo_ren), 32'h0);
            chk($sformatf("idle_sof@%0d", i),  32'(tdm_sof),  32'h0);
            @(negedge clk);
        end
        slot_sel = 2'd3;
        restart();
        run_span(0, 4, NONE, NONE, NONE, NONE);

        // Asynchronous reset mid-burst clears outputs before the next edge
        slot_sel = 2'd0;
        push_words(8'h60, 8);
        restart();
        run_span(0, 3, 0, 7, NONE, NONE);
        #2 rst = 1'b1;
        #1 chk_zero_outputs("async_rst");
        exp_q.delete();
        fifo_q.delete();
        @(negedge clk);
        push_words(8'h70, 8);
        rst = 1'b0;
        @(negedge clk);
        chk("skip_after_rst", 32'(skip_cnt), 32'd0);
        run_span(0, 60, 0, 7, NONE, NONE);

        en = 1'b0;
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("fifo_q_drained", 32'(fifo_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
